cycle_capture: RTL and testbench
================================

# cycle_capture

Measurement controller paired with the cycle counter: gates the counter's enable, timestamps start/stop events against the counter's running value, and returns elapsed cycle counts to the host over a valid/ready handshake. It sits beside the counter; `counterEnable_o` feeds the counter's enable and the counter's output returns on `counter_i`. It adds a timeout, abort, a lost-event flag and a measurement tally.

## Interface
- `COUNTER_SIZE`, 40: width of `counter_i`, `timeout_i` and `elapsed_o`.
- `MEAS_COUNT_SIZE`, 16: width of `measCount_o`.
- `AUTO_REARM`, 0: 1 means return to ARMED, not IDLE, after a result is accepted.
- `clock_i` in 1: single clock. Rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `arm_i` in 1: single-cycle pulse; arms a measurement.
- `start_i` in 1: start event pulse.
- `stop_i` in 1: stop event pulse.
- `abort_i` in 1: cancels the measurement in progress; no result is produced.
- `clearLost_i` in 1: clears `lost_o`.
- `counter_i` in COUNTER_SIZE: running value from the cycle counter.
- `timeout_i` in COUNTER_SIZE: timeout limit in cycles; 0 disables the timeout.
- `counterEnable_o` out 1: registered; drives the counter's enable input.
- `elapsed_o` out COUNTER_SIZE: measurement result.
- `timedOut_o` out 1: the result was ended by the timeout, not by `stop_i`.
- `valid_o` out 1: a result is held.
- `ready_i` in 1: host accepts the result.
- `busy_o` out 1: state is ARMED or RUNNING.
- `lost_o` out 1: sticky; an event arrived while a result was pending.
- `measCount_o` out MEAS_COUNT_SIZE: count of accepted results; saturates.

## Operation
- The block has four states: IDLE, ARMED, RUNNING and DONE.
- Priority is abort > stop > timeout > start > arm.
- **IDLE:** `arm_i` moves to ARMED. All other inputs are ignored.
- **ARMED:**
  - `start_i` stores `startStamp = counter_i` and moves to RUNNING.
  - `start_i` and `stop_i` in the same cycle move to DONE with `elapsed_o = 0`.
  - `abort_i` moves to IDLE.
- **RUNNING:**
  - The block computes `diff = counter_i - startStamp`, modulo 2^COUNTER_SIZE, so counter wrap-around is handled.
  - `stop_i` latches `elapsed_o = diff`, clears `timedOut_o` and moves to DONE.
  - If `timeout_i != 0`, `diff >= timeout_i` and `stop_i` is low, the block latches `elapsed_o = diff`, sets `timedOut_o` and moves to DONE.
  - A stop and a timeout in the same cycle resolve as a stop.
  - `start_i` is ignored.
  - `abort_i` moves to IDLE.
- **DONE:**
  - `valid_o` is 1. `elapsed_o` and `timedOut_o` stay stable until the result is accepted.
  - `valid_o & ready_i` accepts the result:
    - `measCount_o` increments, saturating at all-ones.
    - The next state is IDLE, or ARMED if AUTO_REARM = 1.
  - `start_i` or `stop_i` sets `lost_o`.
  - `abort_i` drops the result: next state is IDLE, `measCount_o` is unchanged, and abort beats a simultaneous accept.
- `arm_i` outside IDLE is ignored.
- `lost_o`:
  - Set as above.
  - Cleared by `clearLost_i`.
  - A set and a clear in the same cycle leave it set.

## Timing
- **Reset:** asserting `reset_i` at a clock edge gives:
  - state IDLE;
  - every output 0, including `elapsed_o`, `measCount_o` and `lost_o`;
  - `startStamp` 0.
- Reset mid-measurement discards everything. No result is emitted.
- `counter_i` is sampled in the same cycle as the `start_i` or `stop_i` pulse.
- `valid_o` rises on the next edge: stop-to-valid latency is 1 cycle.
- `counterEnable_o = 1` iff the registered state is ARMED or RUNNING. It follows the state by 0 cycles because it is decoded from the state register.
- Only `counter_i` differences are used, so the counter's enable-to-count lag does not bias results.
- With `ready_i` held high, DONE lasts exactly 1 cycle.
- The earliest next measurement is: AUTO_REARM = 1, start 1 cycle after accept; AUTO_REARM = 0, arm 1 cycle after accept.
- The timeout comparison is unsigned, full COUNTER_SIZE width, evaluated combinationally each RUNNING cycle.

## Structure
- The state encoding goes in shared package `ept_pkg`, as `capture_state_t` with members IDLE, ARMED, RUNNING, DONE. Widths stay local parameters.
- There is no sub-module: one FSM plus datapath registers (`startStamp`, `elapsed`, `measCount`, `lost`).
- This block is instantiated beside `counter` in the measurement top, with matching COUNTER_SIZE.

## Test plan
- **Basic measurement:** arm; start with `counter_i` = 100; stop with `counter_i` = 350; `ready_i` = 1.
  - Required: `elapsed_o` = 250, `timedOut_o` = 0, `valid_o` for 1 cycle, `measCount_o` = 1.
- **Wrap-around:** COUNTER_SIZE = 8; start at 250; stop at 4.
  - Required: `elapsed_o` = 10.
- **Timeout:** `timeout_i` = 20; start at 0; `counter_i` reaches 20 with no stop.
  - Required: `elapsed_o` = 20, `timedOut_o` = 1.
  - Repeat with the stop at 20 in that same cycle: `timedOut_o` = 0.
- **Backpressure:** hold `ready_i` = 0 for 5 cycles after the result; pulse `stop_i` during the hold.
  - Required: `elapsed_o` stable throughout, `lost_o` = 1, `measCount_o` increments only on the accept.
  - Then `clearLost_i`: `lost_o` = 0.
- **Abort and reset:** `abort_i` in RUNNING.
  - Required: IDLE, `counterEnable_o` = 0, no `valid_o`.
  - Then `reset_i` in DONE: all outputs 0 next cycle.
- **Edge cases:**
  - `start_i` and `stop_i` together in ARMED: `elapsed_o` = 0.
  - AUTO_REARM = 1: after accept, `busy_o` = 1 with no `arm_i`.

Source files
------------

// File: rtl/ept_pkg.sv
// Shared types for the elapsed-time measurement slice.
// Holds the capture controller state encoding; widths stay local to each module.
package ept_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RUNNING = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

endpackage

// File: rtl/cycle_capture.sv
// Measurement controller beside the cycle counter: gates its enable, timestamps
// start/stop against its running value and hands elapsed counts to the host.
module cycle_capture
   import ept_pkg::*;
#(
   parameter int COUNTER_SIZE    = 40,
   parameter int MEAS_COUNT_SIZE = 16,
   parameter bit AUTO_REARM      = 1'b0
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       arm_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic                       abort_i,
   input  logic                       clearLost_i,
   input  logic [COUNTER_SIZE-1:0]    counter_i,
   input  logic [COUNTER_SIZE-1:0]    timeout_i,
   output logic                       counterEnable_o,
   output logic [COUNTER_SIZE-1:0]    elapsed_o,
   output logic                       timedOut_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       busy_o,
   output logic                       lost_o,
   output logic [MEAS_COUNT_SIZE-1:0] measCount_o
);

   capture_state_t              state_q, state_d;
   logic [COUNTER_SIZE-1:0]     startStamp_q, startStamp_d;
   logic [COUNTER_SIZE-1:0]     elapsed_q, elapsed_d;
   logic                        timedOut_q, timedOut_d;
   logic                        lost_q, lost_d;
   logic [MEAS_COUNT_SIZE-1:0]  measCount_q, measCount_d;
   logic [COUNTER_SIZE-1:0]     diff;
   logic                        timeoutHit;

   // Modular subtraction absorbs counter wrap-around between start and now.
   assign diff       = counter_i - startStamp_q;
   assign timeoutHit = (timeout_i != '0) && (diff >= timeout_i);

   always_comb begin
      state_d      = state_q;
      startStamp_d = startStamp_q;
      elapsed_d    = elapsed_q;
      timedOut_d   = timedOut_q;
      measCount_d  = measCount_q;
      lost_d       = lost_q;

      unique case (state_q)
         IDLE: begin
            if (arm_i) state_d = ARMED;
         end
         ARMED: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (start_i && stop_i) begin
               elapsed_d  = '0;
               timedOut_d = 1'b0;
               state_d    = DONE;
            end else if (start_i) begin
               startStamp_d = counter_i;
               state_d      = RUNNING;
            end
         end
         RUNNING: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (stop_i) begin
               elapsed_d  = diff;
               timedOut_d = 1'b0;
               state_d    = DONE;
            end else if (timeoutHit) begin
               elapsed_d  = diff;
               timedOut_d = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (ready_i) begin
               if (measCount_q != '1) measCount_d = measCount_q + 1'b1;
               state_d = AUTO_REARM ? ARMED : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A clear and a new event in the same cycle leaves the flag set.
      if (clearLost_i) lost_d = 1'b0;
      if ((state_q == DONE) && (start_i || stop_i)) lost_d = 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         startStamp_q <= '0;
         elapsed_q    <= '0;
         timedOut_q   <= 1'b0;
         lost_q       <= 1'b0;
         measCount_q  <= '0;
      end else begin
         state_q      <= state_d;
         startStamp_q <= startStamp_d;
         elapsed_q    <= elapsed_d;
         timedOut_q   <= timedOut_d;
         lost_q       <= lost_d;
         measCount_q  <= measCount_d;
      end
   end

   // Status outputs decode straight from the state register.
   assign counterEnable_o = (state_q == ARMED) || (state_q == RUNNING);
   assign busy_o          = counterEnable_o;
   assign valid_o         = (state_q == DONE);
   assign elapsed_o       = elapsed_q;
   assign timedOut_o      = timedOut_q;
   assign lost_o          = lost_q;
   assign measCount_o     = measCount_q;

endmodule

// File: tb/tb_cycle_capture.sv
// Directed bench for cycle_capture: a 40-bit instance, an 8-bit instance for
// wrap-around and an auto-rearm instance, all sharing the control inputs.
module tb_cycle_capture;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        arm = 1'b0, start = 1'b0, stop = 1'b0, abort = 1'b0;
   logic        clearLost = 1'b0, ready = 1'b0;
   logic [39:0] counter = '0, timeout = '0;

   logic        counterEnable, timedOut, valid, busy, lost;
   logic [39:0] elapsed;
   logic [15:0] measCount;

   logic        counterEnable8, timedOut8, valid8, busy8, lost8;
   logic [7:0]  elapsed8;
   logic [15:0] measCount8;

   logic        counterEnableRe, timedOutRe, validRe, busyRe, lostRe;
   logic [39:0] elapsedRe;
   logic [15:0] measCountRe;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   cycle_capture #(.COUNTER_SIZE(40), .MEAS_COUNT_SIZE(16), .AUTO_REARM(1'b0)) dut (
      .clock_i(clock), .reset_i(reset), .arm_i(arm), .start_i(start), .stop_i(stop),
      .abort_i(abort), .clearLost_i(clearLost), .counter_i(counter), .timeout_i(timeout),
      .counterEnable_o(counterEnable), .elapsed_o(elapsed), .timedOut_o(timedOut),
      .valid_o(valid), .ready_i(ready), .busy_o(busy), .lost_o(lost), .measCount_o(measCount)
   );

   cycle_capture #(.COUNTER_SIZE(8), .MEAS_COUNT_SIZE(16), .AUTO_REARM(1'b0)) dut8 (
      .clock_i(clock), .reset_i(reset), .arm_i(arm), .start_i(start), .stop_i(stop),
      .abort_i(abort), .clearLost_i(clearLost), .counter_i(counter[7:0]), .timeout_i(timeout[7:0]),
      .counterEnable_o(counterEnable8), .elapsed_o(elapsed8), .timedOut_o(timedOut8),
      .valid_o(valid8), .ready_i(ready), .busy_o(busy8), .lost_o(lost8), .measCount_o(measCount8)
   );

   cycle_capture #(.COUNTER_SIZE(40), .MEAS_COUNT_SIZE(16), .AUTO_REARM(1'b1)) dutRe (
      .clock_i(clock), .reset_i(reset), .arm_i(arm), .start_i(start), .stop_i(stop),
      .abort_i(abort), .clearLost_i(clearLost), .counter_i(counter), .timeout_i(timeout),
      .counterEnable_o(counterEnableRe), .elapsed_o(elapsedRe), .timedOut_o(timedOutRe),
      .valid_o(validRe), .ready_i(ready), .busy_o(busyRe), .lost_o(lostRe), .measCount_o(measCountRe)
   );

   // Advance one clock and settle just past the edge before any checks.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      arm = 0; start = 0; stop = 0; abort = 0; clearLost = 0; ready = 0;
      counter = '0; timeout = '0;
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if ({counterEnable, timedOut, valid, busy, lost} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got %b want 00000", {counterEnable, timedOut, valid, busy, lost});
      end
      checks++;
      if (elapsed !== 40'd0 || measCount !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_data elapsed=%0d count=%0d want 0 0", elapsed, measCount);
      end
   endtask

   task automatic test_basic();
      doReset();
      ready = 1;
      arm = 1; tick(); arm = 0;
      checks++;
      if (busy !== 1'b1 || counterEnable !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_armed busy=%b en=%b want 1 1", busy, counterEnable);
      end
      counter = 40'd100; start = 1; tick(); start = 0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_running valid=%b busy=%b want 0 1", valid, busy);
      end
      counter = 40'd350; stop = 1; tick(); stop = 0;
      checks++;
      if (valid !== 1'b1 || elapsed !== 40'd250 || timedOut !== 1'b0 || measCount !== 16'd0) begin
         failures++;
         $display("[TB] FAIL basic_result valid=%b elapsed=%0d to=%b count=%0d want 1 250 0 0",
                  valid, elapsed, timedOut, measCount);
      end
      tick();
      checks++;
      if (valid !== 1'b0 || measCount !== 16'd1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_accept valid=%b count=%0d busy=%b want 0 1 0", valid, measCount, busy);
      end
      ready = 0;
   endtask

   task automatic test_wrap();
      doReset();
      arm = 1; tick(); arm = 0;
      counter = 40'd250; start = 1; tick(); start = 0;
      counter = 40'd4; stop = 1; tick(); stop = 0;
      checks++;
      if (valid8 !== 1'b1 || elapsed8 !== 8'd10) begin
         failures++;
         $display("[TB] FAIL wrap_elapsed valid=%b elapsed=%0d want 1 10", valid8, elapsed8);
      end
   endtask

   task automatic test_timeout();
      doReset();
      timeout = 40'd20;
      arm = 1; tick(); arm = 0;
      counter = 40'd0; start = 1; tick(); start = 0;
      counter = 40'd10; tick();
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_early valid=%b want 0", valid);
      end
      counter = 40'd20; tick();
      checks++;
      if (valid !== 1'b1 || elapsed !== 40'd20 || timedOut !== 1'b1) begin
         failures++;
         $display("[TB] FAIL timeout_hit valid=%b elapsed=%0d to=%b want 1 20 1", valid, elapsed, timedOut);
      end
      ready = 1; tick(); ready = 0;
      arm = 1; tick(); arm = 0;
      counter = 40'd0; start = 1; tick(); start = 0;
      counter = 40'd20; stop = 1; tick(); stop = 0;
      checks++;
      if (valid !== 1'b1 || elapsed !== 40'd20 || timedOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_vs_stop valid=%b elapsed=%0d to=%b want 1 20 0", valid, elapsed, timedOut);
      end
      ready = 1; tick(); ready = 0;
      timeout = '0;
   endtask

   task automatic test_backpressure();
      doReset();
      arm = 1; tick(); arm = 0;
      counter = 40'd1000; start = 1; tick(); start = 0;
      counter = 40'd1500; stop = 1; tick(); stop = 0;
      for (int i = 0; i < 5; i++) begin
         stop = (i == 2);
         tick();
         stop = 0;
         checks++;
         if (valid !== 1'b1 || elapsed !== 40'd500 || measCount !== 16'd0) begin
            failures++;
            $display("[TB] FAIL hold_%0d valid=%b elapsed=%0d count=%0d want 1 500 0", i, valid, elapsed, measCount);
         end
      end
      checks++;
      if (lost !== 1'b1) begin
         failures++;
         $display("[TB] FAIL lost_set got %b want 1", lost);
      end
      ready = 1; tick(); ready = 0;
      checks++;
      if (valid !== 1'b0 || measCount !== 16'd1) begin
         failures++;
         $display("[TB] FAIL bp_accept valid=%b count=%0d want 0 1", valid, measCount);
      end
      clearLost = 1; tick(); clearLost = 0;
      checks++;
      if (lost !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lost_clear got %b want 0", lost);
      end
   endtask

   task automatic test_abort();
      doReset();
      arm = 1; tick(); arm = 0;
      counter = 40'd5; start = 1; tick(); start = 0;
      abort = 1; tick(); abort = 0;
      checks++;
      if (busy !== 1'b0 || counterEnable !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_running busy=%b en=%b valid=%b want 0 0 0", busy, counterEnable, valid);
      end
      arm = 1; tick(); arm = 0;
      start = 1; tick(); start = 0;
      counter = 40'd9; stop = 1; tick(); stop = 0;
      abort = 1; ready = 1; tick(); abort = 0; ready = 0;
      checks++;
      if (valid !== 1'b0 || measCount !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_beats_accept valid=%b count=%0d busy=%b want 0 0 0", valid, measCount, busy);
      end
      arm = 1; tick(); arm = 0;
      counter = 40'd10; start = 1; tick(); start = 0;
      counter = 40'd17; stop = 1; tick(); stop = 1; tick(); stop = 0;
      checks++;
      if (valid !== 1'b1 || lost !== 1'b1 || elapsed !== 40'd7) begin
         failures++;
         $display("[TB] FAIL pre_reset_done valid=%b lost=%b elapsed=%0d want 1 1 7", valid, lost, elapsed);
      end
      reset = 1; tick(); reset = 0;
      checks++;
      if ({counterEnable, timedOut, valid, busy, lost} !== 5'b0 || elapsed !== 40'd0 || measCount !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_in_done flags=%b elapsed=%0d count=%0d want 00000 0 0",
                  {counterEnable, timedOut, valid, busy, lost}, elapsed, measCount);
      end
   endtask

   task automatic test_start_stop_same();
      doReset();
      arm = 1; tick(); arm = 0;
      counter = 40'd77; start = 1; stop = 1; tick(); start = 0; stop = 0;
      checks++;
      if (valid !== 1'b1 || elapsed !== 40'd0 || timedOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_stop_same valid=%b elapsed=%0d to=%b want 1 0 0", valid, elapsed, timedOut);
      end
   endtask

   task automatic test_auto_rearm();
      doReset();
      arm = 1; tick(); arm = 0;
      counter = 40'd30; start = 1; tick(); start = 0;
      counter = 40'd45; stop = 1; tick(); stop = 0;
      checks++;
      if (validRe !== 1'b1 || elapsedRe !== 40'd15) begin
         failures++;
         $display("[TB] FAIL rearm_result valid=%b elapsed=%0d want 1 15", validRe, elapsedRe);
      end
      ready = 1; tick(); ready = 0;
      checks++;
      if (busyRe !== 1'b1 || counterEnableRe !== 1'b1 || validRe !== 1'b0 || measCountRe !== 16'd1) begin
         failures++;
         $display("[TB] FAIL rearm_busy busy=%b en=%b valid=%b count=%0d want 1 1 0 1",
                  busyRe, counterEnableRe, validRe, measCountRe);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL norearm_idle busy=%b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_timeout();
      test_backpressure();
      test_abort();
      test_start_stop_same();
      test_auto_rearm();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
